// File: rtl/spu_pkg.sv
// Shared definitions for the SPU controller: opcodes, FSM states, select codes
// and the instruction word layout.
package spu_pkg;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LDC   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_LOAD,
        ST_EXEC_STORE,
        ST_EXEC_ALU,
        ST_EXEC_LDC,
        ST_EXEC_JMPZ,
        ST_JMP_TAKE,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        RF_SEL_ALU = 2'b00,
        RF_SEL_DM  = 2'b01,
        RF_SEL_IMM = 2'b10
    } rf_sel_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_AND  = 2'b11
    } alu_sel_e;

    // The 8-bit d/c/offset field is {rb, rc}.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } instr_t;

endpackage

// File: rtl/spu_pc.sv
// SPU program counter: IM_AW-bit register with clear, increment and a relative
// load that is taken from the address of the jump itself (PC-1).
module spu_pc #(
    parameter int IM_AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             jmp,
    input  logic [IM_AW-1:0] offset,
    output logic [IM_AW-1:0] pc
);

    logic [IM_AW-1:0] pc_q, pc_d;

    // The offset arrives already truncated to IM_AW bits, which equals the
    // sign-extended offset modulo 2^IM_AW.
    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + IM_AW'(1);
        end else if (jmp) begin
            pc_d = pc_q - IM_AW'(1) + offset;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/spu_ctrl_v2.sv
// SPU next-generation controller with handshaked memories.
// Optional memory-wait timeout: define SPU_MEM_TIMEOUT_EN.
module spu_ctrl_v2
    import spu_pkg::*;
#(
    parameter int IM_AW      = 8,
    parameter int DM_AW      = 8,
    parameter int RF_AW      = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             stop,
    output logic             err,
    input  logic [15:0]      im_r_data,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_rd,
    input  logic             im_ready,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_rd,
    output logic             dm_wr,
    input  logic             dm_ready,
    output logic             rf_s1,
    output logic             rf_s0,
    output logic [7:0]       rf_w_data,
    output logic [RF_AW-1:0] rf_w_addr,
    output logic             rf_w_wr,
    output logic [RF_AW-1:0] rf_rp_addr,
    output logic             rf_rp_rd,
    output logic [RF_AW-1:0] rf_rq_addr,
    output logic             rf_rq_rd,
    input  logic             rf_rp_zero,
    output logic             alu_s1,
    output logic             alu_s0
);

`ifdef SPU_MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_e            state_q, state_d;
    instr_t            ir_q, ir_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wait_expired;
    logic              pc_clr, pc_inc, pc_jmp;
    logic [IM_AW-1:0]  pc_q;
    logic [7:0]        d_field;
    rf_sel_e           rf_sel;
    alu_sel_e          alu_sel;

    assign d_field      = {ir_q.rb, ir_q.rc};
    assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_W'(WAIT_LIMIT - 1));

    spu_pc #(.IM_AW(IM_AW)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .clr    (pc_clr),
        .inc    (pc_inc),
        .jmp    (pc_jmp),
        .offset (d_field[IM_AW-1:0]),
        .pc     (pc_q)
    );

    // NOTE: every output and next-state value gets a default first, so no
    // path through the case below can infer a latch.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        err_d      = err_q;
        pc_clr     = 1'b0;
        pc_inc     = 1'b0;
        pc_jmp     = 1'b0;
        stop       = 1'b0;
        im_addr    = '0;
        im_rd      = 1'b0;
        dm_addr    = '0;
        dm_rd      = 1'b0;
        dm_wr      = 1'b0;
        rf_sel     = RF_SEL_ALU;
        rf_w_data  = '0;
        rf_w_addr  = '0;
        rf_w_wr    = 1'b0;
        rf_rp_addr = '0;
        rf_rp_rd   = 1'b0;
        rf_rq_addr = '0;
        rf_rq_rd   = 1'b0;
        alu_sel    = ALU_PASS;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                stop = 1'b1;
                if (start) begin
                    pc_clr  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                im_rd   = 1'b1;
                im_addr = pc_q;
                if (im_ready) begin
                    ir_d    = instr_t'(im_r_data);
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                case (ir_q.op)
                    OP_LOAD:                state_d = ST_EXEC_LOAD;
                    OP_STORE:               state_d = ST_EXEC_STORE;
                    OP_ADD, OP_SUB, OP_AND: state_d = ST_EXEC_ALU;
                    OP_LDC:                 state_d = ST_EXEC_LDC;
                    OP_JMPZ:                state_d = ST_EXEC_JMPZ;
                    OP_JMP:                 state_d = ST_JMP_TAKE;
                    OP_HALT:                state_d = ST_HALT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_EXEC_LOAD: begin
                dm_rd     = 1'b1;
                dm_addr   = d_field[DM_AW-1:0];
                rf_sel    = RF_SEL_DM;
                rf_w_addr = ir_q.ra;
                if (dm_ready) begin
                    rf_w_wr = 1'b1;
                    state_d = ST_FETCH;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC_STORE: begin
                // The ALU passes RF[ra] through to the datapath's dm_w_data.
                dm_wr      = 1'b1;
                dm_addr    = d_field[DM_AW-1:0];
                rf_rp_addr = ir_q.ra;
                rf_rp_rd   = 1'b1;
                if (dm_ready) begin
                    state_d = ST_FETCH;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC_ALU: begin
                rf_rp_addr = ir_q.rb;
                rf_rp_rd   = 1'b1;
                rf_rq_addr = ir_q.rc;
                rf_rq_rd   = 1'b1;
                case (ir_q.op)
                    OP_ADD:  alu_sel = ALU_ADD;
                    OP_SUB:  alu_sel = ALU_SUB;
                    default: alu_sel = ALU_AND;
                endcase
                rf_w_addr = ir_q.ra;
                rf_w_wr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_EXEC_LDC: begin
                rf_sel    = RF_SEL_IMM;
                rf_w_data = d_field;
                rf_w_addr = ir_q.ra;
                rf_w_wr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_EXEC_JMPZ: begin
                rf_rp_addr = ir_q.ra;
                rf_rp_rd   = 1'b1;
                state_d    = rf_rp_zero ? ST_JMP_TAKE : ST_FETCH;
            end
            ST_JMP_TAKE: begin
                pc_jmp  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        wait_d = '0;
        if (TIMEOUT_EN && (state_d == state_q) &&
            (state_q inside {ST_FETCH, ST_EXEC_LOAD, ST_EXEC_STORE})) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign {rf_s1, rf_s0}   = rf_sel;
    assign {alu_s1, alu_s0} = alu_sel;
    assign err              = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

endmodule
